// File: rtl/ram_bank_loader.sv
// ============================================================================
//  Module   : ram_bank_loader
//  Purpose  : Write-side controller for the 13-bank x 19-word x 16-bit input
//             feature buffer. Accepts a raster-order pixel stream over a
//             valid/ready handshake and writes row r, column c into bank r at
//             address c. Pulses done once all 247 words are committed.
//  Ports    : clk, rst (sync, active-high)
//             start        - one-cycle pulse, begins a frame load (IDLE only)
//             s_data/s_valid/s_ready - pixel stream handshake
//             addr_write   - shared bank write address
//             wr_data      - write data broadcast to every bank
//             write_enable - per-bank write strobes (bit r -> bank r)
//             busy, done   - frame status; done is a one-cycle pulse
//             row_idx      - current destination bank
//  Options  : LOADER_ZERO_FILL_EN - when defined, start first zero-fills all
//             banks (DEPTH cycles of all-ones strobes) before loading.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_bank_loader #(
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 13,
  parameter int DEPTH     = 19,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDR_W-1:0]    addr_write,
  output logic [DATA_W-1:0]    wr_data,
  output logic [NUM_BANKS-1:0] write_enable,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           row_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_COL = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        c_LAST_ROW = 4'(NUM_BANKS - 1);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_row,   w_row_nxt;
  logic [ADDR_W-1:0]      r_col,   w_col_nxt;
  logic [ADDR_W-1:0]      r_addr,  w_addr_nxt;
  logic [DATA_W-1:0]      r_data,  w_data_nxt;
  logic [NUM_BANKS-1:0]   r_we,    w_we_nxt;
  logic                   r_done,  w_done_nxt;
  logic                   w_beat;

  // Ready and busy decode the registered state only, so s_ready never
  // depends combinationally on s_valid.
  assign s_ready      = (r_state == S_LOAD);
  assign busy         = (r_state != S_IDLE);
  assign w_beat       = s_valid & s_ready;

  assign addr_write   = r_addr;
  assign wr_data      = r_data;
  assign write_enable = r_we;
  assign done         = r_done;
  assign row_idx      = r_row;

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we_nxt    = '0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_row_nxt = '0;
          w_col_nxt = '0;
`ifdef LOADER_ZERO_FILL_EN
          // The first clear strobe is presented in the first CLEAR cycle.
          w_state_nxt = S_CLEAR;
          w_we_nxt    = '1;
          w_addr_nxt  = '0;
          w_data_nxt  = '0;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end

`ifdef LOADER_ZERO_FILL_EN
      // r_col tracks the address currently being zeroed.
      S_CLEAR: begin
        if (r_col == c_LAST_COL) begin
          w_state_nxt = S_LOAD;
          w_col_nxt   = '0;
        end else begin
          w_col_nxt  = r_col + ADDR_W'(1);
          w_addr_nxt = r_col + ADDR_W'(1);
          w_we_nxt   = '1;
        end
      end
`endif

      S_LOAD: begin
        if (w_beat) begin
          w_addr_nxt = r_col;
          w_data_nxt = s_data;
          w_we_nxt   = NUM_BANKS'(1) << r_row;
          if (r_col == c_LAST_COL) begin
            // Final beat leaves the counters on the last word so row_idx
            // never leaves 0..NUM_BANKS-1.
            if (r_row == c_LAST_ROW) begin
              w_state_nxt = S_FLUSH;
            end else begin
              w_col_nxt = '0;
              w_row_nxt = r_row + 4'd1;
            end
          end else begin
            w_col_nxt = r_col + ADDR_W'(1);
          end
        end
      end

      // The last strobe is on the bus during this cycle; done follows it.
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule

`default_nettype wire
